// File: rtl/router_pkg.sv
// -----------------------------------------------------------------------------
// router_pkg
// Shared constants and helpers for the router datapath: the default port count
// and starvation timeout, and the constant functions that size the address
// field and the per-port timer. Used by the synchroniser, its timer sub-module,
// the output FIFOs and the router top level.
// -----------------------------------------------------------------------------
package router_pkg;

    localparam int DEFAULT_NUM_PORTS = 3;
    localparam int DEFAULT_TIMEOUT   = 30;

    // Ceiling log2, usable in parameter expressions. clog2(1) = 0.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Address field width: a single-bit field is kept even when only one
    // encoding would be needed, so the port never collapses to zero width.
    function automatic int addr_width(input int num_ports);
        int w;
        w = clog2(num_ports);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/router_sync_timer.sv
// -----------------------------------------------------------------------------
// router_sync_timer
// Starvation watchdog for one output FIFO. Counts consecutive clock edges on
// which the FIFO holds data (vld) but is not being read (rd). On the
// TIMEOUT-th such edge it raises soft_reset for exactly one cycle and starts
// counting again from zero, so a FIFO that stays abandoned is flushed every
// TIMEOUT cycles.
//
// Ports:
//   clk         in   system clock, rising edge
//   resetn      in   asynchronous active-low reset
//   vld         in   FIFO holds data (non-empty)
//   rd          in   FIFO read enable from the destination side
//   soft_reset  out  one-cycle FIFO flush pulse
// -----------------------------------------------------------------------------
module router_sync_timer
    import router_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int CNT_W   = clog2(TIMEOUT + 1)
) (
    input  logic clk,
    input  logic resetn,
    input  logic vld,
    input  logic rd,
    output logic soft_reset
);

    // The count stops at TIMEOUT-1 and is cleared on the expiring edge,
    // so it can never wrap regardless of CNT_W.
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count      <= '0;
            soft_reset <= 1'b0;
        end else if (!vld || rd) begin
            // Either nothing to read or the reader is alive: not starved.
            count      <= '0;
            soft_reset <= 1'b0;
        end else if (count == LAST_COUNT) begin
            count      <= '0;
            soft_reset <= 1'b1;
        end else begin
            count      <= count + 1'b1;
            soft_reset <= 1'b0;
        end
    end

endmodule

// File: rtl/router_sync_n.sv
// -----------------------------------------------------------------------------
// router_sync_n
// Synchroniser between the router FSM/register block and NUM_PORTS output
// FIFOs. Latches the destination address from the header byte, steers the
// FSM's write request to the addressed FIFO, returns that FIFO's full flag to
// the FSM, publishes per-port valid flags and runs one starvation timer per
// port that flushes FIFOs left unread for TIMEOUT cycles. Addresses at or
// beyond NUM_PORTS are flagged and their packets are dropped.
//
// Ports:
//   clk            in   system clock, all state on rising edge
//   resetn         in   asynchronous active-low reset
//   detect_add     in   header strobe; latch datain on this edge
//   write_enb_reg  in   FSM write request for the current byte
//   datain         in   destination address field of the header byte
//   full           in   per-FIFO full flags
//   empty          in   per-FIFO empty flags
//   read_enb       in   per-FIFO read enables from the destination side
//   write_enb      out  one-hot (or zero) FIFO write enables
//   fifo_full      out  full flag of the currently addressed FIFO
//   vld_out        out  per-port data-valid (FIFO non-empty)
//   soft_reset     out  per-port one-cycle FIFO flush pulse
//   addr_err       out  latched address is not a valid port
// -----------------------------------------------------------------------------
module router_sync_n
    import router_pkg::*;
#(
    parameter int NUM_PORTS = DEFAULT_NUM_PORTS,
    parameter int TIMEOUT   = DEFAULT_TIMEOUT,
    parameter int ADDR_W    = addr_width(NUM_PORTS),
    parameter int CNT_W     = clog2(TIMEOUT + 1)
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 detect_add,
    input  logic                 write_enb_reg,
    input  logic [ADDR_W-1:0]    datain,
    input  logic [NUM_PORTS-1:0] full,
    input  logic [NUM_PORTS-1:0] empty,
    input  logic [NUM_PORTS-1:0] read_enb,
    output logic [NUM_PORTS-1:0] write_enb,
    output logic                 fifo_full,
    output logic [NUM_PORTS-1:0] vld_out,
    output logic [NUM_PORTS-1:0] soft_reset,
    output logic                 addr_err
);

    // One extra bit so NUM_PORTS itself is representable even when it is a
    // power of two (e.g. 4 ports with a 2-bit address field).
    localparam logic [ADDR_W:0] PORT_LIMIT = (ADDR_W + 1)'(NUM_PORTS);

    logic [ADDR_W-1:0] addr_reg;
    logic              sel_full;

    // Address latch. A header on the same edge as a write request only takes
    // effect for the following byte; the current byte still uses addr_reg.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            addr_reg <= '0;
            addr_err <= 1'b0;
        end else if (detect_add) begin
            addr_reg <= datain;
            addr_err <= ({1'b0, datain} >= PORT_LIMIT);
        end
    end

    // Write-enable decode and full-flag mux. The loop compares against each
    // legal port only, so an out-of-range addr_reg selects nothing and never
    // indexes past the end of full[].
    always_comb begin
        write_enb = '0;
        sel_full  = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (addr_reg == ADDR_W'(i)) begin
                write_enb[i] = write_enb_reg & ~addr_err;
                sel_full     = full[i];
            end
        end
    end

    // A bad address reports "not full" so the FSM keeps consuming the packet,
    // whose bytes are silently dropped by the gated write enables above.
    assign fifo_full = ~addr_err & sel_full;

    assign vld_out = ~empty;

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_timer
        router_sync_timer #(
            .TIMEOUT (TIMEOUT),
            .CNT_W   (CNT_W)
        ) u_timer (
            .clk        (clk),
            .resetn     (resetn),
            .vld        (vld_out[g]),
            .rd         (read_enb[g]),
            .soft_reset (soft_reset[g])
        );
    end

endmodule

// File: doc/router_sync_n.md
Name: router_sync_n

Overview:
Parametrised successor to the 1x3 router synchroniser, sitting between the router FSM/register block and NUM_PORTS output FIFOs.
- Latches the destination address on header detect and steers the write enable to one FIFO.
- Muxes the selected FIFO's full flag back to the FSM and drives per-port valid outputs.
- Runs a per-port starvation timer that issues a one-cycle soft reset to any FIFO left unread for TIMEOUT cycles.
- New against the 3-port version: arbitrary port count, configurable timeout, and invalid-address detection with packet drop.

Parameters:
- NUM_PORTS, 3, number of output FIFOs/channels (2..16).
- TIMEOUT, 30, consecutive unread-valid cycles before soft reset (1..255).
- ADDR_W, max(1, clog2(NUM_PORTS)), width of datain address field (derived).
- CNT_W, clog2(TIMEOUT+1), per-port timer width (derived).

Ports:
- clk  in  1  system clock, all state on rising edge
- resetn  in  1  asynchronous active-low reset
- detect_add  in  1  header-byte strobe from FSM; latch address this cycle
- write_enb_reg  in  1  FSM write request for current byte
- datain  in  ADDR_W  destination address field of header byte
- full  in  NUM_PORTS  per-FIFO full flags
- empty  in  NUM_PORTS  per-FIFO empty flags
- read_enb  in  NUM_PORTS  per-FIFO read enables from destination side
- write_enb  out  NUM_PORTS  one-hot (or zero) FIFO write enables
- fifo_full  out  1  full flag of currently addressed FIFO
- vld_out  out  NUM_PORTS  per-port data-valid
- soft_reset  out  NUM_PORTS  per-port one-cycle FIFO flush pulse
- addr_err  out  1  latched address >= NUM_PORTS

Behaviour:
- Reset: on resetn low, immediately (async) clear addr_reg=0, addr_err=0, all timers=0, soft_reset=0. write_enb, fifo_full and vld_out are combinational and follow inputs, so during reset: write_enb=0 if write_enb_reg=0, fifo_full=full[0], vld_out=~empty.
- Address latch: at a rising edge with detect_add=1, addr_reg<=datain and addr_err<=(datain>=NUM_PORTS). Otherwise both hold.
- Same-cycle detect_add and write_enb_reg: write_enb uses the pre-edge addr_reg. The new address takes effect the cycle after.
- write_enb[i] = write_enb_reg & ~addr_err & (addr_reg==i). Zero-cycle latency. At most one bit high.
- fifo_full = addr_err ? 0 : full[addr_reg]. An invalid address never stalls the FSM; its bytes are dropped because write_enb stays 0.
- The block does not gate writes on full. The FSM must honour fifo_full.
- vld_out[i] = ~empty[i], combinational.
- Per-port timer i, evaluated each edge:
  - If vld_out[i]=0 or read_enb[i]=1: timer<=0, soft_reset[i]<=0.
  - Else, if timer==TIMEOUT-1: timer<=0, soft_reset[i]<=1.
  - Else: timer<=timer+1, soft_reset[i]<=0.
  - Net effect: soft_reset[i] rises after the TIMEOUT-th consecutive starved edge and is high for exactly one cycle.
- After a pulse, if the FIFO is still non-empty and unread, counting restarts from 0. The next pulse comes TIMEOUT cycles later; no lockout.
- A read_enb[i] pulse on any cycle clears the count, including the cycle the count would expire. That suppresses the pulse.
- Timers are independent. Several ports may pulse on the same cycle.
- Timer never exceeds TIMEOUT-1, so there is no wrap.
- resetn asserted mid-count discards progress. After release, counting starts from 0.

Decomposition:
- router_pkg: default NUM_PORTS and TIMEOUT, plus a clog2 constant function used by ADDR_W and CNT_W. Shared with the FIFO and top-level.
- One sub-module, router_sync_timer (params TIMEOUT, CNT_W; ports clk, resetn, vld, rd, soft_reset). Instantiated NUM_PORTS times in a generate loop.
- The top module holds the address latch, error flag, write-enable decode and full mux.

Test Plan:
- Reset, then detect_add=1, datain=1, next cycle write_enb_reg=1 -> write_enb=3'b010, fifo_full=full[1]. Toggle full[1] and see fifo_full follow with zero latency.
- detect_add=1 with datain=2 and write_enb_reg=1 in the same cycle, prior addr=0 -> that cycle write_enb=3'b001; next cycle write_enb=3'b100.
- NUM_PORTS=3, datain=3 latched -> addr_err=1, write_enb=0 with write_enb_reg=1, fifo_full=0 even with full=3'b111. Relatching datain=0 -> addr_err=0.
- empty_0=0, read_enb_0=0 held -> soft_reset[0] high exactly one cycle after the 30th edge, then low. Holding a further 30 cycles gives a second pulse.
- Same starvation with read_enb_0 pulsed at edge 29 -> no pulse, count restarts. empty_0=1 at edge 15 -> no pulse. Ports 1 and 2 starved together -> simultaneous pulses.
- resetn asserted between clock edges at count 20 -> soft_reset and addr_err drop immediately. After release, a pulse needs a full 30 new cycles. Repeat with NUM_PORTS=5, TIMEOUT=4 to confirm pulse after the 4th edge.
